// File: rtl/mc_ar_arbiter.sv
// Shares one memory-controller AR/R channel pair between three DRAM-cache requesters.
// AR is round-robin arbitrated and source-tagged in the top ARID bits; R beats route back by tag.
module mc_ar_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned ID_WIDTH        = 16,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3*ID_WIDTH-1:0]   s_arid_i,
  input  logic [3*ADDR_WIDTH-1:0] s_araddr_i,
  input  logic [3*8-1:0]          s_arlen_i,
  input  logic [2:0]              s_arvalid_i,
  output logic [2:0]              s_arready_o,
  output logic [ID_WIDTH-1:0]     m_arid_o,
  output logic [ADDR_WIDTH-1:0]   m_araddr_o,
  output logic [7:0]              m_arlen_o,
  output logic                    m_arvalid_o,
  input  logic                    m_arready_i,
  input  logic [ID_WIDTH-1:0]     m_rid_i,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i,
  input  logic                    m_rlast_i,
  input  logic                    m_rvalid_i,
  output logic                    m_rready_o,
  output logic [ID_WIDTH-1:0]     s_rid_o,
  output logic [DATA_WIDTH-1:0]   s_rdata_o,
  output logic                    s_rlast_o,
  output logic [2:0]              s_rvalid_o,
  input  logic [2:0]              s_rready_i,
  output logic                    err_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_ptr, r_src;
  logic [CW-1:0]         r_cnt [3];
  logic [ID_WIDTH-1:0]   r_arid;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic                  r_err;

  logic [2:0]            w_elig;
  logic [1:0]            w_c1, w_c2, w_c3;
  logic [1:0]            w_grant;
  logic                  w_grant_vld;
  logic [ID_WIDTH-1:0]   w_sel_id;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [7:0]            w_sel_len;
  logic [1:0]            w_dest;
  logic                  w_ar_hs, w_r_done, w_bad_tag;
  logic [2:0]            w_inc, w_dec, w_underflow;

  always_comb begin
    for (int unsigned s = 0; s < 3; s++) begin
      w_elig[s] = s_arvalid_i[s] && (r_cnt[s] < CW'(MAX_OUTSTANDING));
    end
  end

  // Search order ptr+1, ptr+2, ptr+3 (mod 3); ptr+3 wraps back to ptr itself.
  always_comb begin
    w_c1        = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
    w_c2        = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;
    w_c3        = r_ptr;
    w_grant     = '0;
    w_grant_vld = 1'b0;
    if (w_elig[w_c1]) begin
      w_grant     = w_c1;
      w_grant_vld = 1'b1;
    end else if (w_elig[w_c2]) begin
      w_grant     = w_c2;
      w_grant_vld = 1'b1;
    end else if (w_elig[w_c3]) begin
      w_grant     = w_c3;
      w_grant_vld = 1'b1;
    end
  end

  always_comb begin
    w_sel_id   = s_arid_i[0 +: ID_WIDTH];
    w_sel_addr = s_araddr_i[0 +: ADDR_WIDTH];
    w_sel_len  = s_arlen_i[0 +: 8];
    case (w_grant)
      2'd1: begin
        w_sel_id   = s_arid_i[ID_WIDTH +: ID_WIDTH];
        w_sel_addr = s_araddr_i[ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_len  = s_arlen_i[8 +: 8];
      end
      2'd2: begin
        w_sel_id   = s_arid_i[2*ID_WIDTH +: ID_WIDTH];
        w_sel_addr = s_araddr_i[2*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_len  = s_arlen_i[16 +: 8];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    s_arready_o = '0;
    m_arvalid_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_vld) begin
          s_arready_o[w_grant] = rst_n;
          w_state_nxt          = SEND;
        end
      end
      SEND: begin
        m_arvalid_o = 1'b1;
        if (m_arready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= 2'd2;
      r_src    <= '0;
      r_arid   <= '0;
      r_araddr <= '0;
      r_arlen  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_grant_vld) begin
        r_ptr    <= w_grant;
        r_src    <= w_grant;
        r_arid   <= {w_grant, w_sel_id[ID_WIDTH-3:0]};
        r_araddr <= w_sel_addr;
        r_arlen  <= w_sel_len;
      end
    end
  end

  assign m_arid_o   = r_arid;
  assign m_araddr_o = r_araddr;
  assign m_arlen_o  = r_arlen;

  assign w_dest = m_rid_i[ID_WIDTH-1 -: 2];

  // Tag 3 has no owner: accept and drop the beat so the controller never stalls on it.
  always_comb begin
    s_rvalid_o = '0;
    m_rready_o = 1'b1;
    if (w_dest != 2'd3) begin
      s_rvalid_o[w_dest] = m_rvalid_i;
      m_rready_o         = s_rready_i[w_dest];
    end
  end

  assign s_rid_o   = {2'b00, m_rid_i[ID_WIDTH-3:0]};
  assign s_rdata_o = m_rdata_i;
  assign s_rlast_o = m_rlast_i;

  assign w_ar_hs   = (r_state == SEND) && m_arready_i;
  assign w_r_done  = m_rvalid_i && m_rready_o && m_rlast_i && (w_dest != 2'd3);
  assign w_bad_tag = m_rvalid_i && (w_dest == 2'd3);

  always_comb begin
    for (int unsigned s = 0; s < 3; s++) begin
      w_inc[s]       = w_ar_hs && (r_src == 2'(s));
      w_dec[s]       = w_r_done && (w_dest == 2'(s));
      w_underflow[s] = w_dec[s] && !w_inc[s] && (r_cnt[s] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < 3; s++) r_cnt[s] <= '0;
      r_err <= 1'b0;
    end else begin
      for (int unsigned s = 0; s < 3; s++) begin
        if (w_inc[s] && !w_dec[s]) begin
          r_cnt[s] <= r_cnt[s] + CW'(1);
        end else if (w_dec[s] && !w_inc[s] && (r_cnt[s] != '0)) begin
          r_cnt[s] <= r_cnt[s] - CW'(1);
        end
      end
      r_err <= r_err | w_bad_tag | (|w_underflow);
    end
  end

  assign err_o = r_err;

endmodule

// File: doc/mc_ar_arbiter.md
# mc_ar_arbiter

- Shares the single memory-controller AR/R channel pair between three DRAM-cache requesters:
  - source 0: tag/metadata lookup from the index extractor;
  - source 1: miss fill fetch;
  - source 2: victim read for writeback.
- Arbitrates AR requests round-robin, tags each with its source in the upper ARID bits, and routes R beats back by that tag.
- Tracks per-source outstanding bursts and throttles any source at its limit.

## Interface
Parameters:
- ADDR_WIDTH, 64, AR address width
- ID_WIDTH, 16, AXI ID width; top 2 bits carry the source tag
- DATA_WIDTH, 512, R data width
- MAX_OUTSTANDING, 8, max in-flight bursts per source (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- s_arid_i  in  3*ID_WIDTH  per-source ARID, source s at [s*ID_WIDTH +: ID_WIDTH]
- s_araddr_i  in  3*ADDR_WIDTH  per-source address
- s_arlen_i  in  3*8  per-source burst length
- s_arvalid_i  in  3  per-source request valid
- s_arready_o  out  3  per-source accept, one-hot or zero
- m_arid_o  out  ID_WIDTH  tagged ID to memory controller
- m_araddr_o  out  ADDR_WIDTH  address to memory controller
- m_arlen_o  out  8  burst length to memory controller
- m_arvalid_o  out  1  request valid to memory controller
- m_arready_i  in  1  memory controller accept
- m_rid_i  in  ID_WIDTH  R ID from memory controller
- m_rdata_i  in  DATA_WIDTH  R data
- m_rlast_i  in  1  R last beat
- m_rvalid_i  in  1  R valid
- m_rready_o  out  1  R ready to memory controller
- s_rid_o  out  ID_WIDTH  R ID to sources, tag bits zeroed
- s_rdata_o  out  DATA_WIDTH  R data, broadcast to all sources
- s_rlast_o  out  1  R last, broadcast
- s_rvalid_o  out  3  per-source R valid, one-hot or zero
- s_rready_i  in  3  per-source R ready
- err_o  out  1  sticky flag: an R beat carried an invalid source tag

## Operation
FSM states are IDLE and SEND.

- IDLE:
  - Source s is eligible when s_arvalid_i[s] = 1 and outstanding[s] < MAX_OUTSTANDING.
  - Grant is the first eligible source in the order ptr+1, ptr+2, ptr+3 (mod 3), where ptr is the last granted source.
  - s_arready_o[grant] = 1 combinationally in this cycle.
  - At the clock edge:
    - capture m_arid_o = {src[1:0], s_arid[ID_WIDTH-3:0]}, plus the address and length;
    - set ptr = grant;
    - go to SEND.
  - The upper 2 bits of a source's ARID are overwritten.
- SEND:
  - m_arvalid_o = 1; the captured fields are held stable.
  - All s_arready_o = 0.
  - On m_arready_i = 1: increment outstanding[src] and go to IDLE.
- Outstanding counters:
  - One per source, width $clog2(MAX_OUTSTANDING+1).
  - Decrement on an R handshake (m_rvalid_i & m_rready_o & m_rlast_i) for the tagged source.
  - Simultaneous increment and decrement on the same source leaves the counter unchanged.
  - A counter never wraps below 0; a decrement at 0 is ignored and sets err_o.
- R routing is combinational, with dest = m_rid_i[ID_WIDTH-1 -: 2]:
  - dest 0..2:
    - s_rvalid_o[dest] = m_rvalid_i;
    - m_rready_o = s_rready_i[dest].
  - dest 3:
    - all s_rvalid_o = 0 and m_rready_o = 1, so the beat is dropped;
    - err_o is set on m_rvalid_i.
  - In all cases, s_rid_o = {2'b00, m_rid_i[ID_WIDTH-3:0]}, and s_rdata_o and s_rlast_o pass through.
- err_o is cleared only by reset.

## Timing
- Reset values:
  - state = IDLE, ptr = 2, so source 0 has first priority;
  - all counters = 0;
  - m_arvalid_o = 0, m_arid_o / m_araddr_o / m_arlen_o = 0;
  - s_arready_o = 0 while in reset;
  - err_o = 0.
- AR latency: a request accepted at cycle t (s_arready_o pulse) gives m_arvalid_o from t+1.
  - Best case is one request per 2 cycles: grant at t, handshake at t+1, next grant at t+2.
- m_arvalid_o is never deasserted before m_arready_i.
- Arbitration is frozen while in SEND.
- A request arriving during SEND waits; it is not lost as long as the source holds s_arvalid_i.
- R path has zero-cycle latency, no buffering and no AR/R ordering dependence.
  - An R beat may complete in the same cycle as the AR handshake of its own burst only if the memory controller permits it; the counter rules still apply.
- Reset asserted in SEND:
  - the captured request is dropped and counters are cleared;
  - the source must re-issue.

## Test plan
- Single request: src0 id 0x0005, addr 0x1000, len 0, m_arready_i = 1.
  - Required: s_arready_o = 3'b001 at t; m_arvalid_o at t+1 with arid 0x0005, araddr 0x1000; IDLE at t+2.
- Fairness: all three sources held valid, m_arready_i = 1.
  - Required: grant sequence 0, 1, 2, 0, 1, 2 at t, t+2, t+4, …
  - Required: ARID tags 0x0xxx, 0x4xxx, 0x8xxx.
- Backpressure: m_arready_i held 0 for 5 cycles during SEND.
  - Required: m_ar* stable, s_arready_o = 0 throughout, handshake on the 6th cycle.
- Throttle with MAX_OUTSTANDING = 2: src1 issues 2 bursts with no R response.
  - Required: a third src1 request is blocked while src2 is still granted.
  - Then R rlast with rid 0x4003: s_rvalid_o = 3'b010, s_rid_o = 0x0003, and src1 is granted again on the next IDLE.
- Invalid R tag:
  - R rid 0x8007: routed to s_rvalid_o[2] with s_rid_o = 0x0007.
  - R rid 0xC001: m_rready_o = 1, s_rvalid_o = 0, err_o = 1 and sticky.
- Reset in SEND with m_arready_i = 0: assert rst_n = 0 for 1 cycle.
  - Required: m_arvalid_o = 0 and counters = 0 afterwards; the first post-reset grant goes to src0.
